// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: receive side of the 4-digit multiplexed MM:SS seven-segment bus.
// Optional SEG_LAG_COMP_EN: segments lag sel by one slot, captures are attributed to slot-1.
module seg_scan_decoder #(
  parameter int unsigned SETTLE  = 4,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sel,
  input  logic [6:0] digital,
  output logic [7:0] second,
  output logic [7:0] minute,
  output logic       frame_valid,
  output logic       link_up,
  output logic       pat_err,
  output logic       seq_err
);
  localparam int DW = 20;

  logic [3:0]    sel_m, sel_s, sel_p;
  logic [6:0]    dig_m, dig_s, dig_p;
  logic [DW-1:0] dwell;
  logic [15:0]   stage;
  logic [3:0]    mask;
  logic [1:0]    exp_slot;

  logic          changed;
  logic          capture;
  logic          timeout;
  logic          one_hot;
  logic          dig_ok;
  logic          range_ok;
  logic [1:0]    slot;
  logic [1:0]    aslot;
  logic [3:0]    digit;

  assign changed = (sel_s != sel_p) || (dig_s != dig_p);
  // capture on the cycle the dwell count steps to SETTLE-1
  assign capture = !changed && (dwell == DW'(SETTLE - 2))
                   && (sel_s != 4'hF);
  assign timeout = !changed && (dwell == DW'(TIMEOUT - 1));

  always_comb begin
    one_hot = 1'b1;
    slot    = 2'd0;
    unique case (1'b1)
      (sel_s == 4'b1110): slot = 2'd0;
      (sel_s == 4'b1101): slot = 2'd1;
      (sel_s == 4'b1011): slot = 2'd2;
      (sel_s == 4'b0111): slot = 2'd3;
      default:            one_hot = 1'b0;
    endcase
  end

  always_comb begin
    dig_ok = 1'b1;
    digit  = 4'd0;
    unique case (1'b1)
      (dig_s == 7'b0000001): digit = 4'd0;
      (dig_s == 7'b1001111): digit = 4'd1;
      (dig_s == 7'b0010010): digit = 4'd2;
      (dig_s == 7'b0000110): digit = 4'd3;
      (dig_s == 7'b1001100): digit = 4'd4;
      (dig_s == 7'b0100100): digit = 4'd5;
      (dig_s == 7'b0100000): digit = 4'd6;
      (dig_s == 7'b0001111): digit = 4'd7;
      (dig_s == 7'b0000000): digit = 4'd8;
      (dig_s == 7'b0000100): digit = 4'd9;
      default:               dig_ok = 1'b0;
    endcase
  end

`ifdef SEG_LAG_COMP_EN
  assign aslot = slot - 2'd1;
`else
  assign aslot = slot;
`endif

  assign range_ok = !(aslot[0] && (digit > 4'd5));

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_m       <= '0;
      sel_s       <= '0;
      sel_p       <= '0;
      dig_m       <= '0;
      dig_s       <= '0;
      dig_p       <= '0;
      dwell       <= '0;
      stage       <= '0;
      mask        <= '0;
      exp_slot    <= '0;
      second      <= '0;
      minute      <= '0;
      frame_valid <= 1'b0;
      link_up     <= 1'b0;
      pat_err     <= 1'b0;
      seq_err     <= 1'b0;
    end else begin
      sel_m       <= sel;
      sel_s       <= sel_m;
      sel_p       <= sel_s;
      dig_m       <= digital;
      dig_s       <= dig_m;
      dig_p       <= dig_s;
      frame_valid <= 1'b0;
      pat_err     <= 1'b0;
      seq_err     <= 1'b0;

      if (changed)
        dwell <= '0;
      else if (dwell != DW'(TIMEOUT))
        dwell <= dwell + 1'b1;

      if (capture) begin
        if (!one_hot || !dig_ok || !range_ok) begin
          pat_err  <= 1'b1;
          mask     <= '0;
          exp_slot <= '0;
        end else if (aslot != exp_slot) begin
          seq_err <= 1'b1;
          if (aslot == 2'd0) begin
            stage[3:0] <= digit;
            mask       <= 4'b0001;
            exp_slot   <= 2'd1;
          end else begin
            mask     <= '0;
            exp_slot <= '0;
          end
        end else begin
          stage[{aslot, 2'b00} +: 4] <= digit;
          if (aslot == 2'd3 && mask == 4'b0111) begin
            second      <= stage[7:0];
            minute      <= {digit, stage[11:8]};
            frame_valid <= 1'b1;
            link_up     <= 1'b1;
            mask        <= '0;
            exp_slot    <= '0;
          end else begin
            mask[aslot] <= 1'b1;
            exp_slot    <= aslot + 2'd1;
          end
        end
      end else if (timeout) begin
        link_up  <= 1'b0;
        mask     <= '0;
        exp_slot <= '0;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: dwell-level reference model,
// expected pulses queued at stimulus time and popped by a monitor.
module tb_seg_scan_decoder;
  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sel = 4'hF;
  logic [6:0] digital = 7'h7F;
  logic [7:0] second, minute;
  logic       frame_valid, link_up, pat_err, seq_err;

  seg_scan_decoder #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .sel(sel), .digital(digital),
    .second(second), .minute(minute), .frame_valid(frame_valid),
    .link_up(link_up), .pat_err(pat_err), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         kind;
    logic [7:0] sec;
    logic [7:0] min;
  } ev_t;

  localparam logic [6:0] SEG [10] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
  };
  localparam logic [3:0] SELS [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  ev_t        q[$];
  int         total = 0;
  int         passed = 0;
  int         m_exp;
  int         m_dig [4];
  logic [7:0] m_sec, m_min;
  logic       m_link;
  logic [3:0] prev_s;
  logic [6:0] prev_d;
  int         run;
  bit         cap_done;
  int         lag_last;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s actual=%0h required=%0h", nm, act, req);
  endtask

  function automatic int dec(input logic [6:0] p);
    for (int i = 0; i < 10; i++)
      if (SEG[i] == p) return i;
    return -1;
  endfunction

  function automatic int slot_of(input logic [3:0] s);
    for (int i = 0; i < 4; i++)
      if (SELS[i] == s) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_exp  = 0;
    m_sec  = 8'h00;
    m_min  = 8'h00;
    m_link = 1'b0;
    for (int i = 0; i < 4; i++) m_dig[i] = 0;
  endtask

  // one capture as seen from the spec's rules
  task automatic model(input logic [3:0] s, input logic [6:0] p);
    int  sl, d, a;
    ev_t e;
    e = '{0, 8'h00, 8'h00};
    if (s == 4'hF) return;
    sl = slot_of(s);
    d  = dec(p);
`ifdef SEG_LAG_COMP_EN
    a = (sl < 0) ? -1 : (sl + 3) % 4;
`else
    a = sl;
`endif
    if (sl < 0 || d < 0 || (a % 2 == 1 && d > 5)) begin
      e.kind = 1; q.push_back(e); m_exp = 0;
    end else if (a != m_exp) begin
      e.kind = 2; q.push_back(e);
      if (a == 0) begin m_dig[0] = d; m_exp = 1; end
      else m_exp = 0;
    end else begin
      m_dig[a] = d;
      if (a == 3) begin
        m_sec  = 8'(m_dig[1] * 16 + m_dig[0]);
        m_min  = 8'(m_dig[3] * 16 + m_dig[2]);
        m_link = 1'b1;
        m_exp  = 0;
        e.kind = 0; e.sec = m_sec; e.min = m_min;
        q.push_back(e);
      end else m_exp = a + 1;
    end
  endtask

  task automatic drive(input logic [3:0] s, input logic [6:0] p, input int n);
    if (s !== prev_s || p !== prev_d) begin
      run = 0; cap_done = 0; prev_s = s; prev_d = p;
    end
    run += n;
    if (!cap_done && run >= SETTLE) begin
      cap_done = 1;
      model(s, p);
    end
    sel = s;
    digital = p;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input int d0, input int d1, input int d2, input int d3);
    int dd [4];
    dd = '{d0, d1, d2, d3};
    for (int k = 0; k < 4; k++) begin
`ifdef SEG_LAG_COMP_EN
      drive(SELS[k], SEG[k == 0 ? lag_last : dd[k-1]], 15);
`else
      drive(SELS[k], SEG[dd[k]], 15);
`endif
    end
    lag_last = d3;
  endtask

  task automatic settle_frame();
`ifdef SEG_LAG_COMP_EN
    drive(SELS[0], SEG[lag_last], 15);
`else
    drive(4'hF, 7'h7F, 15);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1; sel = 4'hF; digital = 7'h7F;
    prev_s = 4'hF; prev_d = 7'h7F; cap_done = 1; run = 0; lag_last = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_second", second, 0);
    check("rst_minute", minute, 0);
    check("rst_pulses", {frame_valid, pat_err, seq_err}, 0);
    check("rst_link_up", link_up, 0);
    rst = 1'b0;
  endtask

  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (!rst && (frame_valid || pat_err || seq_err)) begin
        if (q.size() == 0) begin
          total++;
          $display("FAIL unexpected_pulse fv/pe/se=%b required none",
                   {frame_valid, pat_err, seq_err});
        end else begin
          e = q.pop_front();
          check("pulse_kind", {frame_valid, pat_err, seq_err},
                e.kind == 0 ? 3'b100 : e.kind == 1 ? 3'b010 : 3'b001);
          if (e.kind == 0) begin
            check("frame_second", second, e.sec);
            check("frame_minute", minute, e.min);
            check("frame_link_up", link_up, 1);
          end
        end
      end
    end
  end

  initial begin
    int r;
    logic [3:0] s;
    logic [6:0] p;
    do_reset();

    send(7, 4, 2, 1);
    settle_frame();
    check("first_second", second, 8'h47);
    check("first_minute", minute, 8'h12);
    check("first_link_up", link_up, 1);

    send(3, 6, 5, 0);
    settle_frame();
    send(0, 3, 4, 2);
    settle_frame();

    drive(SELS[0], SEG[1], 15);
    drive(SELS[2], SEG[2], 15);
    drive(SELS[1], SEG[3], 15);
    drive(SELS[3], SEG[4], 15);
    drive(4'hF, 7'h7F, 15);
    send(9, 5, 9, 5);
    settle_frame();
    check("ff_second", second, 8'h59);
    check("ff_minute", minute, 8'h59);

    for (int i = 0; i < 6; i++) drive(SELS[0], SEG[i % 2 == 0 ? 1 : 8], 3);
    drive(4'hF, 7'h7F, 10);
    check("toggle_second", second, m_sec);
    check("toggle_minute", minute, m_min);

    send(5, 5, 5, 5);
    settle_frame();
    drive(SELS[0], SEG[2], 60);
    check("pre_timeout_link", link_up, m_link);
    drive(SELS[0], SEG[2], 70);
    m_link = 1'b0; m_exp = 0;
    check("timeout_link", link_up, m_link);
    check("timeout_second", second, m_sec);
    check("timeout_minute", minute, m_min);

    drive(SELS[1], SEG[3], 15);
    drive(SELS[2], SEG[4], 15);
    do_reset();

    for (int i = 0; i < 120; i++) begin
      r = $urandom_range(0, 9);
      s = SELS[i % 4];
      p = SEG[(i % 2 == 1) ? $urandom_range(0, 5) : $urandom_range(0, 9)];
      if (r == 7) s = SELS[$urandom_range(0, 3)];
      else if (r == 8) s = 4'($urandom);
      else if (r == 9) p = 7'($urandom);
      drive(s, p, (r == 6) ? 2 : $urandom_range(5, 14));
    end
    drive(4'hF, 7'h7F, 20);
    check("queue_drained", q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
